aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequencer for the 128-bit AES key expander. On a start request it loads the cipher key into the expander by pulsing kld. It then captures the 11 successive round keys from wo_0..wo_3 into a local round-key buffer. Once the buffer is full it serves random-access reads, e.g. reverse-order reads for the decrypt round pipeline.

Parameters:
NR, 10, number of AES rounds; the buffer holds NR+1 round keys.
EXP_LAT, 1, cycles from the kld_o assertion cycle to round key 0 appearing on wo_*.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  request a new key expansion; sampled with key_in
key_in  in  128  cipher key, bits [127:96] = first word
busy  out  1  expansion in progress (LOAD, WAIT or CAPTURE)
ready  out  1  buffer holds a complete, valid schedule
done  out  1  one-cycle pulse on entry to READY
kld_o  out  1  to expander kld
key_o  out  128  to expander key; registered copy of key_in
wi_0, wi_1, wi_2, wi_3  in  32 each  from expander wo_0..wo_3
rd_req  in  1  read request
rd_idx  in  4  round index, 0..NR
rd_vld  out  1  read data valid, one cycle after rd_req
rd_key  out  128  {w0,w1,w2,w3} of the requested round
rd_err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset values: FSM=IDLE; busy=0, ready=0, done=0, kld_o=0, key_o=0, rd_vld=0, rd_key=0, rd_err=0; round counter=0. Buffer contents are don't-care but are marked invalid via ready=0.
- States: IDLE, LOAD, WAIT, CAPTURE, READY.
- IDLE or READY with start=1: latch key_in into key_o, clear ready, go to LOAD.
- start while busy=1 is ignored; key_o is not changed.
- LOAD: kld_o=1 for exactly one cycle, then go to WAIT.
  - With EXP_LAT=1, WAIT lasts 0 cycles and LOAD goes directly to CAPTURE.
  - In general WAIT lasts EXP_LAT-1 cycles.
- CAPTURE: each cycle write {wi_0,wi_1,wi_2,wi_3} into buffer[cnt], then cnt++.
  - After writing cnt=NR, go to READY with ready=1 and done=1 for that first READY cycle.
- Latency with default parameters: start sampled at edge 0; kld_o high in cycle 1; captures occur in cycles 2..12; ready=1 and done=1 in cycle 13.
- Reads are registered. rd_req at edge t with ready=1 and rd_idx<=NR gives rd_vld=1 and rd_key=buffer[rd_idx] in cycle t+1.
- Rejected reads: if ready=0 or rd_idx>NR, then rd_vld=0 and rd_err=1 in cycle t+1; rd_key holds its previous value.
- rd_vld and rd_err are never both high.
- start and rd_req at the same edge while READY: the read is served from the old schedule. ready drops from the next cycle; the buffer is overwritten starting 2 cycles later.
- rst asserted mid-expansion, at any state: next cycle is IDLE with all outputs at reset values. kld_o deasserts immediately. A partially captured schedule is never reported ready.
- The round counter is 4 bits and never wraps; it is cleared on every entry to LOAD.

Test Plan:
1. Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c connected to a real aes_key_expand_128 -> kld_o high in cycle 1 only; done pulse in cycle 13; read idx 0 -> 2b7e1516...4f3c; read idx 1 -> a0fafe1788542cb123a339392a6c7605; read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_vld exactly 1 cycle after each request.
2. Reverse read sweep, idx 10 down to 0 on back-to-back cycles -> 11 consecutive rd_vld pulses with matching FIPS-197 keys and no bubbles.
3. rd_req during CAPTURE, and rd_idx=11 or 15 in READY -> rd_err=1 and rd_vld=0 one cycle later; rd_key unchanged.
4. Second start with key 000102030405060708090a0b0c0d0e0f at cycle 5 of a running expansion -> ignored; key_o unchanged; done at cycle 13 with the first key's schedule.
5. rst pulse at cycle 6 of an expansion -> IDLE, ready=0; a subsequent read -> rd_err. A new start then completes normally in 13 cycles.
6. start plus rd_req(idx 10) at the same edge in READY -> old idx-10 key returned; ready=0 the next cycle; new done 13 cycles later.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 key expander: loads the cipher key, then captures
// NR+1 round keys into a local buffer and serves random-access round-key reads.
// Reads are registered (1 cycle); a start request is ignored while busy.
module aes_key_sched_ctrl #(
  parameter int NR      = 10,
  parameter int EXP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         ready,
  output logic         done,
  output logic         kld_o,
  output logic [127:0] key_o,
  input  logic [31:0]  wi_0,
  input  logic [31:0]  wi_1,
  input  logic [31:0]  wi_2,
  input  logic [31:0]  wi_3,
  input  logic         rd_req,
  input  logic [3:0]   rd_idx,
  output logic         rd_vld,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_READY
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NR);
  // WAIT is only entered when EXP_LAT > 1; it then lasts EXP_LAT-1 cycles
  localparam logic [7:0] WAIT_LAST = (EXP_LAT > 1) ? 8'(EXP_LAT - 2) : 8'd0;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   cnt;
  logic [7:0]   wait_cnt;
  logic [127:0] rk_mem [0:NR];
  logic         rd_ok;
  logic         start_acc;

  // A start is only honoured when no expansion is in flight
  assign start_acc = start && ((state == S_IDLE) || (state == S_READY));
  assign rd_ok     = ready && (rd_idx <= LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_READY: if (start) state_nxt = S_LOAD;
      S_LOAD:          state_nxt = (EXP_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:          if (wait_cnt == WAIT_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE:       if (cnt == LAST_IDX) state_nxt = S_READY;
      default:         state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    kld_o = 1'b0;
    case (state)
      S_LOAD:            begin busy = 1'b1; kld_o = 1'b1; end
      S_WAIT, S_CAPTURE: busy = 1'b1;
      S_READY:           ready = 1'b1;
      default:           ;
    endcase
  end

  // Key latch, counters, done pulse and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      key_o    <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      rd_vld   <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      done <= (state == S_CAPTURE) && (cnt == LAST_IDX);
      if (start_acc) begin
        key_o    <= key_in;
        cnt      <= '0;
        wait_cnt <= '0;
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      // Counter stops at the last index instead of rolling over
      if ((state == S_CAPTURE) && (cnt != LAST_IDX)) cnt <= cnt + 4'd1;
      rd_vld <= rd_req && rd_ok;
      rd_err <= rd_req && !rd_ok;
      if (rd_req && rd_ok) rd_key <= rk_mem[rd_idx];
    end
  end

  // Round-key buffer; contents are only trusted while ready is high
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) rk_mem[cnt] <= {wi_0, wi_1, wi_2, wi_3};
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 expander feeding the DUT,
// an event-level model of the sequencer, directed scenarios and random traffic.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst, start, rd_req;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic         busy, ready, done, kld_o, rd_vld, rd_err;
  logic [127:0] key_o, rd_key;
  logic [31:0]  wi_0, wi_1, wi_2, wi_3;

  int checks = 0;
  int passed = 0;

  aes_key_sched_ctrl #(.NR(10), .EXP_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .ready(ready), .done(done), .kld_o(kld_o), .key_o(key_o),
    .wi_0(wi_0), .wi_1(wi_1), .wi_2(wi_2), .wi_3(wi_3),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 key expansion (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box = multiplicative inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'hfe;
    logic [7:0] r, s;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    r = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w0 = k[127:96], w1 = k[95:64], w2 = k[63:32], w3 = k[31:0];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < r; i++) begin
      t = {w3[23:0], w3[31:24]};
      t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = xt(rc);
    end
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- expander: key on wo_* the cycle after kld ----------------
  logic [127:0] ex_key = '0;
  int           ex_r   = 0;

  always @(posedge clk) begin
    if (kld_o) begin
      ex_key <= key_o;
      ex_r   <= 0;
    end else if (ex_r < 10) begin
      ex_r <= ex_r + 1;
    end
  end

  always_comb begin
    {wi_0, wi_1, wi_2, wi_3} = round_key(ex_key, ex_r);
  end

  // ---------------- sequencer model (event level) ----------------
  logic         m_busy = 0, m_ready = 0, m_done = 0, m_kld = 0;
  logic         m_vld = 0, m_err = 0, m_run = 0;
  logic [127:0] m_keyo = '0, m_rdkey = '0, m_key = '0;
  logic [127:0] m_sched [0:10];
  int           m_age = 0;

  // An accepted start at edge s makes the schedule of that key ready 13 cycles later
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_ready = 0; m_done = 0; m_kld = 0; m_vld = 0; m_err = 0;
        m_run = 0; m_keyo = '0; m_rdkey = '0;
      end else begin
        m_vld = rd_req && m_ready && (rd_idx <= 4'd10);
        m_err = rd_req && !m_vld;
        if (m_vld) m_rdkey = m_sched[rd_idx];
        m_done = 0;
        m_kld  = 0;
        if (m_run) begin
          m_age++;
          if (m_age == 12) begin
            m_run   = 0;
            m_ready = 1;
            m_done  = 1;
            for (int r = 0; r <= 10; r++) m_sched[r] = round_key(m_key, r);
          end
        end else if (start) begin
          m_keyo  = key_in;
          m_key   = key_in;
          m_run   = 1;
          m_age   = 0;
          m_ready = 0;
          m_kld   = 1;
        end
        m_busy = m_run;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("busy", busy, m_busy);
      chk1("ready", ready, m_ready);
      chk1("done", done, m_done);
      chk1("kld_o", kld_o, m_kld);
      chk128("key_o", key_o, m_keyo);
      chk1("rd_vld", rd_vld, m_vld);
      chk1("rd_err", rd_err, m_err);
      chk128("rd_key", rd_key, m_rdkey);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd_lit(input string name, input logic [3:0] idx,
                        input logic vld_exp, input logic [127:0] key_exp);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
    chk1({name, "_vld"}, rd_vld, vld_exp);
    chk1({name, "_err"}, rd_err, !vld_exp);
    chk128({name, "_key"}, rd_key, key_exp);
  endtask

  // Start with key k at the next edge; returns in cycle 1 of the expansion
  task automatic kick(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_req = 1'b0; rd_idx = '0; key_in = '0;
    chk128("model_k1_rk0", round_key(K1, 0), K1);
    chk128("model_k1_rk1", round_key(K1, 1), K1_RK1);
    chk128("model_k1_rk10", round_key(K1, 10), K1_RK10);
    chk128("model_k2_rk10", round_key(K2, 10), K2_RK10);
    chk_en = 1'b1;
    tick(); tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", ready, 1'b0);
    chk128("rst_key_o", key_o, '0);
    chk128("rst_rd_key", rd_key, '0);
    rst = 1'b0;
    tick();

    // 1: basic expansion, cycle-exact kld/done, FIPS-197 round keys
    kick(K1);
    chk1("t1_kld_c1", kld_o, 1'b1);
    tick();
    chk1("t1_kld_c2", kld_o, 1'b0);
    repeat (10) tick();
    chk1("t1_done_c12", done, 1'b0);
    tick();
    chk1("t1_done_c13", done, 1'b1);
    chk1("t1_ready_c13", ready, 1'b1);
    tick();
    chk1("t1_done_c14", done, 1'b0);
    rd_lit("t1_rd0", 4'd0, 1'b1, K1);
    rd_lit("t1_rd1", 4'd1, 1'b1, K1_RK1);
    rd_lit("t1_rd10", 4'd10, 1'b1, K1_RK10);

    // 2: reverse sweep on back-to-back cycles, no bubbles
    for (int i = 10; i >= 0; i--) begin
      rd_req = 1'b1;
      rd_idx = 4'(i);
      tick();
      chk1("t2_vld", rd_vld, 1'b1);
      chk128("t2_key", rd_key, round_key(K1, i));
    end
    rd_req = 1'b0;
    tick();

    // 3: read during CAPTURE and out-of-range reads are rejected, rd_key held
    kick(K1);
    repeat (3) tick();
    rd_lit("t3_capt", 4'd3, 1'b0, K1);
    repeat (8) tick();
    chk1("t3_done_c13", done, 1'b1);
    rd_lit("t3_idx11", 4'd11, 1'b0, K1);
    rd_lit("t3_idx15", 4'd15, 1'b0, K1);

    // 4: start while busy is ignored
    kick(K1);
    repeat (3) tick();
    start  = 1'b1;
    key_in = K2;
    tick();
    start  = 1'b0;
    chk128("t4_key_o_held", key_o, K1);
    chk1("t4_busy", busy, 1'b1);
    repeat (7) tick();
    tick();
    chk1("t4_done_c13", done, 1'b1);
    rd_lit("t4_rd10", 4'd10, 1'b1, K1_RK10);

    // 5: reset mid-expansion drops everything; a fresh start then completes
    kick(K2);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t5_ready", ready, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_kld", kld_o, 1'b0);
    rd_lit("t5_rd_after_rst", 4'd0, 1'b0, '0);
    kick(K1);
    repeat (11) tick();
    chk1("t5_done_c12", done, 1'b0);
    tick();
    chk1("t5_done_c13", done, 1'b1);
    tick();

    // 6: start and read at the same edge in READY; read sees the old schedule
    start  = 1'b1;
    key_in = K2;
    rd_req = 1'b1;
    rd_idx = 4'd10;
    tick();
    start  = 1'b0;
    rd_req = 1'b0;
    chk1("t6_vld", rd_vld, 1'b1);
    chk128("t6_old_key", rd_key, K1_RK10);
    chk1("t6_ready_dropped", ready, 1'b0);
    repeat (12) tick();
    chk1("t6_done_c13", done, 1'b1);
    rd_lit("t6_new_rd10", 4'd10, 1'b1, K2_RK10);

    // Random traffic against the model
    repeat (3000) begin
      start  = ($urandom_range(0, 15) == 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      rd_req = $urandom_range(0, 1) == 1;
      rd_idx = 4'($urandom_range(0, 15));
      rst    = ($urandom_range(0, 249) == 0);
      tick();
    end
    start  = 1'b0;
    rd_req = 1'b0;
    rst    = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
